// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a circular byte FIFO; frames go out back-to-back.
// Optional even parity bit between data and stop is enabled with `UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       txData,
  input  logic             txValid,
  output logic             txReady,
  output logic             TxD,
  output logic             isBusy,
  output logic             txDone,
  output logic [CNT_W-1:0] fifoCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  state_t           state_q;
  logic [BW-1:0]    baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif
  logic             txd_q, busy_q, done_q;

  logic             push, pop, bit_end;
  logic [7:0]       head;

  assign txReady   = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifoCount = count_q;
  assign TxD       = txd_q;
  assign isBusy    = busy_q;
  assign txDone    = done_q;

  assign push    = txValid && txReady;
  assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));
  // Pop either from idle or on the last stop-bit edge so frames chain with no gap.
  assign pop     = (count_q != '0) &&
                   ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= txData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q  <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            baud_q   <= '0;
            state_q  <= S_START;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            done_q <= 1'b1;
            baud_q <= '0;
            if (pop) begin
              shift_q  <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
              state_q  <= S_START;
              txd_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/timeline reference model checked every cycle, plus a
// serial-line decoder that pops expected bytes from a scoreboard on each txDone.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk, reset, txValid, txReady, TxD, isBusy, txDone;
  logic [7:0]    txData;
  logic [CW-1:0] fifoCount;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .txData(txData), .txValid(txValid), .txReady(txReady),
    .TxD(TxD), .isBusy(isBusy), .txDone(txDone), .fifoCount(fifoCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_frames = 0, n_done = 0, n_hist = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending-byte queue plus remaining cycles of the frame on the line.
  logic [7:0] m_q[$];
  logic [7:0] sb[$];
  logic [7:0] m_cur = 8'h00;
  int         m_rem = 0;
  logic       m_done = 1'b0;
  logic       acc;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      sb.delete();
      m_rem  = 0;
      m_done = 1'b0;
    end else begin
      acc    = txValid && (m_q.size() != DEPTH);
      m_done = (m_rem == 1);
      if (m_q.size() > 0 && m_rem <= 1) begin
        m_cur = m_q.pop_front();
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (acc) begin
        m_q.push_back(txData);
        sb.push_back(txData);
      end
    end
  end

  function automatic logic exp_txd();
    int b;
    if (m_rem == 0) return 1'b1;
    b = (FRAME - m_rem) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  logic       hist [FRAME];
  logic [7:0] got, expb;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fifoCount", fifoCount, m_q.size());
      chk("txReady", txReady, (m_q.size() != DEPTH));
      chk("isBusy", isBusy, (m_rem != 0));
      chk("txDone", txDone, m_done);
      chk("TxD", TxD, exp_txd());
      if (reset) begin
        n_hist = 0;
      end else begin
        if (txDone) begin
          n_done++;
          chk("frame_expected", (sb.size() != 0), 1);
          chk("frame_history", (n_hist >= FRAME), 1);
          if (sb.size() != 0) begin
            expb = sb.pop_front();
            for (int k = 0; k < 8; k++) got[k] = hist[(k + 1) * CPB + 2];
            chk("frame_start", hist[2], 0);
            chk("frame_data", got, expb);
`ifdef UART_TX_PARITY_EN
            chk("frame_parity", hist[9 * CPB + 2], ^expb);
`endif
            chk("frame_stop", hist[(NBITS - 1) * CPB + 2], 1);
            n_frames++;
          end
        end
        for (int i = 0; i < FRAME - 1; i++) hist[i] = hist[i + 1];
        hist[FRAME-1] = TxD;
        n_hist++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    txValid = 1'b1;
    txData  = b;
    step();
    txValid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && !(m_rem == 0 && m_q.size() == 0); i++) step();
    step();
    chk("idle_wait_busy", isBusy, 0);
  endtask

  task automatic wait_rem(input int target, input int budget);
    for (int i = 0; i < budget && m_rem != target; i++) step();
    chk("wait_rem_reached", m_rem, target);
  endtask

  int busy_n, done_at, f0, d0, dens;

  initial begin
    reset   = 1'b1;
    txValid = 1'b0;
    txData  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1;
    chk("rst_TxD", TxD, 1);
    chk("rst_isBusy", isBusy, 0);
    chk("rst_txReady", txReady, 1);
    chk("rst_fifoCount", fifoCount, 0);
    chk("rst_txDone", txDone, 0);
    reset = 1'b0;
    step();

    // Single byte: latency, frame length and busy window.
    send(8'h55);
    chk("lat_pre_fall", TxD, 1);
    chk("lat_count_one", fifoCount, 1);
    step();
    chk("lat_fall", TxD, 0);
    chk("lat_count_zero", fifoCount, 0);
    busy_n = 0;
    done_at = -1;
    for (int i = 0; i < 100; i++) begin
      if (isBusy) busy_n++;
      if (txDone && done_at < 0) done_at = i;
      step();
    end
    chk("single_busy_cycles", busy_n, FRAME);
    chk("single_done_delay", done_at, FRAME);

    // Fill and overflow.
    f0 = n_frames;
    for (int i = 0; i < 6; i++) begin
      txValid = 1'b1;
      txData  = 8'hA1 + 8'(i);
      step();
    end
    txValid = 1'b0;
    chk("burst_full_count", fifoCount, DEPTH);
    chk("burst_not_ready", txReady, 0);
    wait_idle(FRAME * 7);
    chk("burst_frames", n_frames - f0, 5);

    // Simultaneous push and pop on the stop-bit end edge.
    send(8'hB0);
    send(8'hB1);
    send(8'hB2);
    wait_rem(1, FRAME + 4);
    txValid = 1'b1;
    txData  = 8'hC3;
    step();
    txValid = 1'b0;
    chk("simul_count", fifoCount, 2);
    chk("simul_busy", isBusy, 1);
    chk("simul_start", TxD, 0);
    wait_idle(FRAME * 5);

    // Reset during DATA bit 3 with two bytes queued.
    send(8'hD0);
    send(8'hD1);
    send(8'hD2);
    wait_rem(FRAME - 18, FRAME);
    chk("midrst_queued", fifoCount, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_TxD", TxD, 1);
    chk("midrst_count", fifoCount, 0);
    chk("midrst_busy", isBusy, 0);
    d0 = n_done;
    for (int i = 0; i < 100; i++) step();
    chk("midrst_no_done", n_done - d0, 0);

    // Parity patterns (plain frames when parity is not built in).
    send(8'h07);
    wait_idle(FRAME * 2);
    send(8'h03);
    wait_idle(FRAME * 2);

    // Randomized traffic at several densities with occasional resets.
    for (int i = 0; i < 1600; i++) begin
      if (i % 400 == 0) dens = $urandom_range(3, 100);
      txValid = ($urandom_range(0, 99) < dens);
      txData  = 8'($urandom);
      reset   = ($urandom_range(0, 599) == 0);
      step();
    end
    txValid = 1'b0;
    reset   = 1'b0;
    wait_idle(FRAME * (DEPTH + 3));
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
